// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and constants for the frequency meter
//
// Contents:
//   state_e        measurement FSM state (IDLE, MEASURE)
//   CNT_W_DEFAULT  default counter/output width
//   CNT_MAX        saturation value of a default-width counter (2^CNT_W-1)

package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = {CNT_W_DEFAULT{1'b1}};

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - input synchroniser with rising-edge detector
//
// Ports:
//   clock  in   system clock, posedge
//   rst_n  in   synchronous active-low reset
//   d      in   asynchronous input
//   s      out  synchronised level
//   rise   out  high for one cycle when s goes 0 -> 1

module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], d};
            s_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - period and high-time meter for a slow periodic signal
//
// Ports:
//   clock       in   system clock, posedge
//   rst_n       in   synchronous active-low reset
//   sig_in      in   asynchronous signal under measurement
//   period      out  last measured period, clock cycles
//   high_cnt    out  high cycles within the last measured period
//   meas_valid  out  one-cycle pulse when period/high_cnt update
//   no_sig      out  set when no rising edge is seen for 2^CNT_W-1 cycles

module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             no_sig
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic s;
    logic rise;

    state_e           state_q;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_cnt_q;
    logic             meas_valid_q;
    logic             no_sig_q;

    logic [CNT_W-1:0] cyc_d;
    logic [CNT_W-1:0] hcnt_d;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock(clock),
        .rst_n(rst_n),
        .d    (sig_in),
        .s    (s),
        .rise (rise)
    );

    // Increments are only committed when cyc_q is below CNT_LIMIT, and
    // hcnt_q never exceeds cyc_q, so neither counter can wrap.
    assign cyc_d  = cyc_q + CNT_ONE;
    assign hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, s};

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            hcnt_q       <= '0;
            period_q     <= '0;
            high_cnt_q   <= '0;
            meas_valid_q <= 1'b0;
            no_sig_q     <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // First edge only opens a measurement window; results
                    // and no_sig stay as they are until a full period is seen.
                    if (rise) begin
                        cyc_q   <= CNT_ONE;
                        hcnt_q  <= CNT_ONE;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_q     <= cyc_q;
                        high_cnt_q   <= hcnt_q;
                        meas_valid_q <= 1'b1;
                        no_sig_q     <= 1'b0;
                        cyc_q        <= CNT_ONE;
                        hcnt_q       <= CNT_ONE;
                    end else if (cyc_q == CNT_LIMIT) begin
                        no_sig_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cyc_q  <= cyc_d;
                        hcnt_q <= hcnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign period     = period_q;
    assign high_cnt   = high_cnt_q;
    assign meas_valid = meas_valid_q;
    assign no_sig     = no_sig_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter

module tb_freq_meter;

    localparam int CNT_W = 8;
    localparam int NSEQ  = 17;

    logic             clock;
    logic             rst_n;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_cnt;
    logic             meas_valid;
    logic             no_sig;

    int n_vec = 0;
    int n_err = 0;

    int cyc_n = 0;
    int v_per[$];
    int v_high[$];
    int v_stamp[$];
    int v_nosig[$];
    int nosig_stamp = -1;
    logic nosig_prev = 1'b0;

    int exp_p[NSEQ];
    int exp_h[NSEQ];

    freq_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_cnt  (high_cnt),
        .meas_valid(meas_valid),
        .no_sig    (no_sig)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always begin
        @(posedge clock);
        #1;
        cyc_n++;
        if (meas_valid === 1'b1) begin
            v_per.push_back(int'(period));
            v_high.push_back(int'(high_cnt));
            v_stamp.push_back(cyc_n);
            v_nosig.push_back(int'(no_sig));
        end
        if (no_sig === 1'b1 && nosig_prev !== 1'b1) nosig_stamp = cyc_n;
        nosig_prev = no_sig;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic v);
        @(negedge clock);
        sig_in = v;
    endtask

    task automatic run_pattern(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) drive(1'b1);
            for (int i = 0; i < lo; i++) drive(1'b0);
        end
    endtask

    task automatic clear_log();
        v_per.delete();
        v_high.delete();
        v_stamp.delete();
        v_nosig.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_period"}, period, 0);
        check_eq({tag, "_high"}, high_cnt, 0);
        check_eq({tag, "_valid"}, meas_valid, 0);
        check_eq({tag, "_nosig"}, no_sig, 0);
    endtask

    initial begin
        // Expected measurement stream across the div-7, 5/5 and 1/1 phases;
        // each phase's first report closes the last period of the one before.
        for (int i = 0; i < 5; i++) begin exp_p[i] = 7;  exp_h[i] = 3; end
        exp_p[5] = 7; exp_h[5] = 3;
        for (int i = 6; i < 9; i++) begin exp_p[i] = 10; exp_h[i] = 5; end
        exp_p[9] = 10; exp_h[9] = 5;
        for (int i = 10; i < NSEQ; i++) begin exp_p[i] = 2; exp_h[i] = 1; end

        rst_n  = 1'b0;
        sig_in = 1'b0;

        // Reset held while the input toggles.
        for (int i = 0; i < 10; i++) drive(i[0]);
        settle(1);
        check_outputs_zero("reset");
        check_eq("reset_no_valid", v_per.size(), 0);

        @(negedge clock);
        sig_in = 1'b0;
        rst_n  = 1'b1;
        settle(3);
        check_outputs_zero("post_reset");

        // Divide-by-7, then 50%, then 1/1, back to back.
        run_pattern(3, 4, 6);
        check_eq("div7_count", v_per.size(), 5);
        run_pattern(5, 5, 4);
        run_pattern(1, 1, 8);

        // Stall with sig_in low.
        settle(270);
        check_eq("seq_count", v_per.size(), NSEQ);
        if (v_per.size() == NSEQ) begin
            for (int i = 0; i < NSEQ; i++) begin
                check_eq($sformatf("seq_period[%0d]", i), v_per[i], exp_p[i]);
                check_eq($sformatf("seq_high[%0d]", i), v_high[i], exp_h[i]);
            end
            for (int i = 1; i < 5; i++)
                check_eq($sformatf("div7_spacing[%0d]", i), v_stamp[i] - v_stamp[i-1], 7);
            for (int i = 7; i < 10; i++)
                check_eq($sformatf("half_spacing[%0d]", i), v_stamp[i] - v_stamp[i-1], 10);
            for (int i = 11; i < NSEQ; i++)
                check_eq($sformatf("fast_spacing[%0d]", i), v_stamp[i] - v_stamp[i-1], 2);
            check_eq("stall_delay", nosig_stamp - v_stamp[NSEQ-1], 255);
        end
        check_eq("stall_nosig", no_sig, 1);
        check_eq("stall_period", period, 2);
        check_eq("stall_high", high_cnt, 1);

        // Restart: first rise re-arms, no_sig clears with the next valid.
        clear_log();
        run_pattern(3, 4, 1);
        check_eq("restart_nosig_held", no_sig, 1);
        check_eq("restart_no_valid", v_per.size(), 0);
        run_pattern(3, 4, 2);
        check_eq("restart_count", v_per.size(), 2);
        if (v_per.size() == 2) begin
            check_eq("restart_period", v_per[0], 7);
            check_eq("restart_high", v_high[0], 3);
            check_eq("restart_nosig_clr", v_nosig[0], 0);
        end
        check_eq("restart_nosig_now", no_sig, 0);

        // Reset during MEASURE in the low part of a period.
        run_pattern(3, 4, 2);
        for (int i = 0; i < 3; i++) drive(1'b1);
        @(negedge clock);
        sig_in = 1'b0;
        rst_n  = 1'b0;
        clear_log();
        settle(1);
        check_outputs_zero("midrst");
        @(negedge clock);
        rst_n = 1'b1;
        drive(1'b0);
        drive(1'b0);
        run_pattern(3, 4, 3);
        check_eq("midrst_count", v_per.size(), 2);
        if (v_per.size() == 2) begin
            check_eq("midrst_period", v_per[0], 7);
            check_eq("midrst_high", v_high[1], 3);
        end

        // Constant-high input out of reset.
        @(negedge clock);
        rst_n  = 1'b0;
        sig_in = 1'b1;
        settle(3);
        check_outputs_zero("consthi_rst");
        clear_log();
        @(negedge clock);
        rst_n = 1'b1;
        settle(257);
        check_eq("consthi_nosig_before", no_sig, 0);
        settle(1);
        check_eq("consthi_nosig_after", no_sig, 1);
        check_eq("consthi_no_valid", v_per.size(), 0);
        check_eq("consthi_period", period, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
